// File: rtl/motor_pkg.sv
// Shared definitions for the motor sequencer and its motor-side responder,
// so both ends agree on the state encoding and the one-hot select check.
package motor_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SPINUP = 2'd1,
        HOLD   = 2'd2,
        FAULT  = 2'd3
    } motor_state_t;

    // Callers zero-extend their select to 32 bits, so any width up to 32 works.
    function automatic logic is_onehot(input logic [31:0] sel);
        return (sel != 32'd0) && ((sel & (sel - 32'd1)) == 32'd0);
    endfunction

endpackage

// File: rtl/motor_dly_counter.sv
// Loadable down-counter that times the spin-up and hold phases.
module motor_dly_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);

    logic [CNT_W-1:0] count;

    // A load wins over counting; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/motor_cmd_responder.sv
// Motor-side responder: latches a one-hot select on the start strobe, drives
// the enables through SPINUP and HOLD, and pulses dly_finished at each phase end.
module motor_cmd_responder #(
    parameter int N          = 4,
    parameter int CNT_W      = 16,
    parameter int RUN_CYCLES = 50000,
    parameter int GAP_CYCLES = 10000
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         signal_main_motor,
    input  logic [N-1:0] signal_motor,
    output logic         main_motor_en,
    output logic [N-1:0] motor_en,
    output logic         dly_finished,
    output logic         busy,
    output logic         fault,
    output logic         green_led,
    output logic         red_led
);

    import motor_pkg::*;

    localparam logic [CNT_W-1:0] RUN_LOAD = CNT_W'(RUN_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

    motor_state_t     state, next_state;
    logic [N-1:0]     sel_q, sel_d;
    logic             main_en_q, main_en_d;
    logic             cnt_load, cnt_en, cnt_zero;
    logic [CNT_W-1:0] cnt_load_val;

    motor_dly_counter #(.CNT_W(CNT_W)) u_dly_counter (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .en       (cnt_en),
        .zero     (cnt_zero)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            sel_q     <= '0;
            main_en_q <= 1'b0;
        end else begin
            state     <= next_state;
            sel_q     <= sel_d;
            main_en_q <= main_en_d;
        end
    end

    // Strobe and select are only looked at in IDLE and FAULT.
    always_comb begin
        next_state   = state;
        sel_d        = sel_q;
        main_en_d    = 1'b0;
        cnt_load     = 1'b0;
        cnt_load_val = RUN_LOAD;
        cnt_en       = 1'b0;
        case (state)
            IDLE: begin
                if (signal_main_motor) begin
                    if (is_onehot(32'(signal_motor))) begin
                        next_state = SPINUP;
                        sel_d      = signal_motor;
                        main_en_d  = 1'b1;
                        cnt_load   = 1'b1;
                    end else begin
                        next_state = FAULT;
                    end
                end
            end
            SPINUP: begin
                cnt_en    = 1'b1;
                main_en_d = 1'b1;
                if (cnt_zero) begin
                    next_state   = HOLD;
                    main_en_d    = 1'b0;
                    cnt_load     = 1'b1;
                    cnt_load_val = GAP_LOAD;
                end
            end
            HOLD: begin
                cnt_en = 1'b1;
                if (cnt_zero) begin
                    next_state = IDLE;
                    sel_d      = '0;
                end
            end
            FAULT: begin
                if (!signal_main_motor && (signal_motor == '0)) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign main_motor_en = main_en_q;
    assign motor_en      = sel_q;
    assign busy          = (state == SPINUP) || (state == HOLD);
    assign fault         = (state == FAULT);
    assign dly_finished  = busy && cnt_zero;
    assign green_led     = busy;
    assign red_led       = fault;

    a_onehot_en: assert property (@(posedge clk) $onehot0(motor_en));
    a_main_in_spinup: assert property (@(posedge clk) disable iff (rst)
        main_motor_en |-> (state == SPINUP));

    // Back-to-back phase pulses are legitimate when a phase is a single cycle.
    if (RUN_CYCLES > 1 && GAP_CYCLES > 1) begin : g_pulse_chk
        a_no_double_pulse: assert property (@(posedge clk) disable iff (rst)
            dly_finished |=> !dly_finished);
    end

endmodule

// File: tb/tb_motor_cmd_responder.sv
// Directed bench for motor_cmd_responder: one instance with 4/3-cycle phases,
// one with single-cycle phases.
module tb_motor_cmd_responder;

    import motor_pkg::*;

    logic       clk = 1'b0;
    logic       rst_a, smm_a, rst_b, smm_b;
    logic [3:0] sm_a, sm_b;
    logic       mm_a, dly_a, busy_a, fault_a, green_a, red_a;
    logic       mm_b, dly_b, busy_b, fault_b, green_b, red_b;
    logic [3:0] me_a, me_b;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    motor_cmd_responder #(.N(4), .CNT_W(16), .RUN_CYCLES(4), .GAP_CYCLES(3)) dut_a (
        .clk (clk), .rst (rst_a), .signal_main_motor (smm_a), .signal_motor (sm_a),
        .main_motor_en (mm_a), .motor_en (me_a), .dly_finished (dly_a),
        .busy (busy_a), .fault (fault_a), .green_led (green_a), .red_led (red_a)
    );

    motor_cmd_responder #(.N(4), .CNT_W(16), .RUN_CYCLES(1), .GAP_CYCLES(1)) dut_b (
        .clk (clk), .rst (rst_b), .signal_main_motor (smm_b), .signal_motor (sm_b),
        .main_motor_en (mm_b), .motor_en (me_b), .dly_finished (dly_b),
        .busy (busy_b), .fault (fault_b), .green_led (green_b), .red_led (red_b)
    );

    // Expected output vector: {main_en, motor_en, dly, busy, fault, green, red}.
    function automatic logic [9:0] expv(input logic mm, input logic [3:0] me,
                                        input logic dly, input logic bsy, input logic flt);
        return {mm, me, dly, bsy, flt, bsy, flt};
    endfunction

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic applyStimulus(input logic smm, input logic [3:0] sm);
        smm_a = smm;
        sm_a  = sm;
        tick();
    endtask

    task automatic checkOutput(input string tag, input logic [9:0] observed,
                               input logic [9:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %b expected %b", tag, observed, expected);
        end
    endtask

    function automatic logic [9:0] obs_a();
        return {mm_a, me_a, dly_a, busy_a, fault_a, green_a, red_a};
    endfunction

    function automatic logic [9:0] obs_b();
        return {mm_b, me_b, dly_b, busy_b, fault_b, green_b, red_b};
    endfunction

    initial begin
        rst_a = 1'b1; smm_a = 1'b1; sm_a = 4'b0000;
        rst_b = 1'b1; smm_b = 1'b0; sm_b = 4'b0000;

        // Reset held two cycles while the strobe is high
        tick();
        checkOutput("reset_c0", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        tick();
        checkOutput("reset_c1", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        rst_a = 1'b0;
        rst_b = 1'b0;
        applyStimulus(1'b0, 4'b0000);
        checkOutput("post_reset", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        compared++;
        assert (dut_a.state === IDLE) else begin
            mismatched++;
            $error("[TB] FAIL post_reset_state: observed %0d expected %0d", dut_a.state, IDLE);
        end

        // Select without strobe is ignored
        applyStimulus(1'b0, 4'b0100);
        checkOutput("select_only", obs_a(), expv(0, 4'b0000, 0, 0, 0));

        // Normal sequence
        applyStimulus(1'b1, 4'b0010);
        checkOutput("spin_c0", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        applyStimulus(1'b0, 4'b0000);
        checkOutput("spin_c1", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("spin_c2", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("spin_c3_dly", obs_a(), expv(1, 4'b0010, 1, 1, 0));
        tick();
        checkOutput("hold_c4", obs_a(), expv(0, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("hold_c5", obs_a(), expv(0, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("hold_c6_dly", obs_a(), expv(0, 4'b0010, 1, 1, 0));
        tick();
        checkOutput("idle_c7", obs_a(), expv(0, 4'b0000, 0, 0, 0));

        // Multi-hot select faults; fault persists until both inputs are clear
        applyStimulus(1'b1, 4'b0110);
        checkOutput("fault_multihot", obs_a(), expv(0, 4'b0000, 0, 0, 1));
        applyStimulus(1'b1, 4'b0110);
        checkOutput("fault_held", obs_a(), expv(0, 4'b0000, 0, 0, 1));
        applyStimulus(1'b0, 4'b0001);
        checkOutput("fault_sel_nonzero", obs_a(), expv(0, 4'b0000, 0, 0, 1));
        applyStimulus(1'b0, 4'b0000);
        checkOutput("fault_exit", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        applyStimulus(1'b1, 4'b0000);
        checkOutput("fault_zero_sel", obs_a(), expv(0, 4'b0000, 0, 0, 1));
        applyStimulus(1'b0, 4'b0000);
        checkOutput("fault_exit2", obs_a(), expv(0, 4'b0000, 0, 0, 0));

        // Re-strobe during the busy phases is ignored; held strobe restarts
        applyStimulus(1'b1, 4'b0010);
        checkOutput("busy_c0", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        applyStimulus(1'b1, 4'b1000);
        checkOutput("busy_c1", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("busy_c2", obs_a(), expv(1, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("busy_c3_dly", obs_a(), expv(1, 4'b0010, 1, 1, 0));
        tick();
        checkOutput("busy_c4", obs_a(), expv(0, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("busy_c5", obs_a(), expv(0, 4'b0010, 0, 1, 0));
        tick();
        checkOutput("busy_c6_dly", obs_a(), expv(0, 4'b0010, 1, 1, 0));
        tick();
        checkOutput("busy_c7_idle", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        tick();
        checkOutput("restart_c8", obs_a(), expv(1, 4'b1000, 0, 1, 0));
        applyStimulus(1'b0, 4'b0000);
        checkOutput("restart_c9", obs_a(), expv(1, 4'b1000, 0, 1, 0));
        tick();
        tick();
        checkOutput("restart_c11_dly", obs_a(), expv(1, 4'b1000, 1, 1, 0));
        tick();
        checkOutput("restart_hold0", obs_a(), expv(0, 4'b1000, 0, 1, 0));
        tick();
        checkOutput("restart_hold1", obs_a(), expv(0, 4'b1000, 0, 1, 0));

        // Reset in HOLD cycle 1 clears everything; no late pulse follows
        rst_a = 1'b1;
        tick();
        checkOutput("midreset", obs_a(), expv(0, 4'b0000, 0, 0, 0));
        rst_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkOutput($sformatf("after_midreset_%0d", i), obs_a(), expv(0, 4'b0000, 0, 0, 0));
        end

        // Single-cycle phases
        checkOutput("min_idle", obs_b(), expv(0, 4'b0000, 0, 0, 0));
        smm_b = 1'b1;
        sm_b  = 4'b0001;
        tick();
        checkOutput("min_spin_dly", obs_b(), expv(1, 4'b0001, 1, 1, 0));
        smm_b = 1'b0;
        sm_b  = 4'b0000;
        tick();
        checkOutput("min_hold_dly", obs_b(), expv(0, 4'b0001, 1, 1, 0));
        tick();
        checkOutput("min_idle_c2", obs_b(), expv(0, 4'b0000, 0, 0, 0));
        tick();
        checkOutput("min_idle_c3", obs_b(), expv(0, 4'b0000, 0, 0, 0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
